// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Brief    : WIDTH-bit add/subtract with carry-in. The carry chain is cut into
//            STAGES equal slices with one register stage each, and valid/ready
//            flow control on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int c_SLICE_W = WIDTH / STAGES;
    localparam int c_LAST    = STAGES - 1;
    localparam int c_MSB     = WIDTH - 1;

    // Per-stage registers. Full operands travel with every item so that each
    // stage can pick its slice and the last stage can form signed overflow.
    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_carry [STAGES];

    logic             w_stall;
    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;

    // A single global stall freezes every stage, bubbles included.
    assign w_stall   = r_valid[c_LAST] && !out_ready;
    assign w_advance = !w_stall;
    assign in_ready  = !w_stall;
    assign w_b_eff   = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0]     w_a_in;
        logic [WIDTH-1:0]     w_b_in;
        logic [WIDTH-1:0]     w_sum_in;
        logic [WIDTH-1:0]     w_sum_next;
        logic                 w_c_in;
        logic                 w_v_in;
        logic [c_SLICE_W:0]   w_res;

        if (k == 0) begin : g_first
            assign w_a_in   = a;
            assign w_b_in   = w_b_eff;
            assign w_sum_in = '0;
            assign w_c_in   = cin;
            assign w_v_in   = in_valid;
        end else begin : g_next
            assign w_a_in   = r_a[k-1];
            assign w_b_in   = r_b[k-1];
            assign w_sum_in = r_sum[k-1];
            assign w_c_in   = r_carry[k-1];
            assign w_v_in   = r_valid[k-1];
        end

        assign w_res = {1'b0, w_a_in[k*c_SLICE_W +: c_SLICE_W]}
                     + {1'b0, w_b_in[k*c_SLICE_W +: c_SLICE_W]}
                     + {{c_SLICE_W{1'b0}}, w_c_in};

        always_comb begin
            w_sum_next = w_sum_in;
            w_sum_next[k*c_SLICE_W +: c_SLICE_W] = w_res[c_SLICE_W-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
            end else if (w_advance) begin
                r_valid[k] <= w_v_in;
                r_a[k]     <= w_a_in;
                r_b[k]     <= w_b_in;
                r_sum[k]   <= w_sum_next;
                r_carry[k] <= w_res[c_SLICE_W];
            end
        end
    end

    assign out_valid = r_valid[c_LAST];
    assign sum       = r_sum[c_LAST];
    assign carry     = r_carry[c_LAST];
    assign overflow  = (r_a[c_LAST][c_MSB] == r_b[c_LAST][c_MSB])
                    && (r_sum[c_LAST][c_MSB] != r_a[c_LAST][c_MSB]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addsub
// Brief    : Scoreboard bench for pipelined_addsub (WIDTH=8, STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       cin, sub, in_valid, out_ready;
    logic       in_ready, carry, overflow, out_valid;
    logic [7:0] sum;

    pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .carry(carry),
        .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    bit         mon_en = 1'b0;
    logic [9:0] q[$];
    int         xfer_cyc[$];
    bit         held_v = 1'b0;
    logic [9:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Independent reference: one wide add, no slicing.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mc, input logic ms);
        logic [7:0] be;
        logic [8:0] s;
        be = ms ? ~mb : mb;
        s  = {1'b0, ma} + {1'b0, be} + {8'd0, mc};
        return {s[7:0], s[8], (ma[7] == be[7]) && (s[7] != ma[7])};
    endfunction

    // Monitor: pops on every output transfer, checks holds during stalls.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            held_v = 1'b0;
        end else if (mon_en) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {6'd0, sum, carry, overflow}, 16'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk("result", {6'd0, sum, carry, overflow}, {6'd0, e});
                    xfer_cyc.push_back(cyc);
                end
                held_v = 1'b0;
            end else if (out_valid) begin
                if (held_v) chk("stall_stable", {6'd0, sum, carry, overflow}, {6'd0, held});
                held   = {sum, carry, overflow};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic ts, input logic [9:0] exp);
        int n = 0;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                chk("in_ready_timeout", 16'd0, 16'd1);
                break;
            end
        end
        if (in_ready) q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 16'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int sz;
        logic [7:0] ra, rb;
        logic rc, rs;

        // Reset with in_valid high for two cycles.
        rst = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 16'd0);
        chk("rst_sum", sum, 16'd0);
        chk("rst_carry", carry, 16'd0);
        chk("rst_overflow", overflow, 16'd0);
        chk("rst_in_ready", in_ready, 16'd1);
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Directed vectors, expected {sum, carry, overflow} computed by hand.
        send(8'hF0, 8'h1F, 1'b1, 1'b0, {8'h10, 1'b1, 1'b0});
        send(8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1});
        send(8'h05, 8'h07, 1'b1, 1'b1, {8'hFE, 1'b0, 1'b0});
        send(8'h80, 8'h01, 1'b1, 1'b1, {8'h7F, 1'b1, 1'b1});
        send(8'h0F, 8'h01, 1'b0, 1'b0, {8'h10, 1'b0, 1'b0});
        send(8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0});
        send(8'h00, 8'h00, 1'b1, 1'b1, {8'h00, 1'b1, 1'b0});
        send(8'h80, 8'h80, 1'b0, 1'b0, {8'h00, 1'b1, 1'b1});
        send(8'h10, 8'h01, 1'b0, 1'b1, {8'h0E, 1'b1, 1'b0});
        drain();

        // Back-to-back throughput.
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        drain();
        sz = xfer_cyc.size();
        chk("tput_consecutive", 16'(xfer_cyc[sz-1] - xfer_cyc[sz-16]), 16'd15);

        // Back-pressure: fill, hold out_ready low for 3 cycles, release.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 1'b0, {8'h46, 1'b0, 1'b0});
        send(8'hC8, 8'h64, 1'b1, 1'b1, {8'h64, 1'b1, 1'b1});
        fork
            send(8'h0F, 8'hF1, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0});
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 16'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two items in flight: neither may be emitted.
        out_ready = 1'b0;
        send(8'h01, 8'h02, 1'b0, 1'b0, {8'h03, 1'b0, 1'b0});
        send(8'h03, 8'h04, 1'b0, 1'b0, {8'h07, 1'b0, 1'b0});
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 16'd0);
        chk("midrst_in_ready", in_ready, 16'd1);
        repeat (5) @(posedge clk);
        #1;
        send(8'h0F, 8'h01, 1'b0, 1'b0, {8'h10, 1'b0, 1'b0});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the team's single-bit half adder.
- Performs a WIDTH-bit add or subtract with carry-in.
- The carry chain is split into STAGES equal slices, one register stage per slice, with valid/ready flow control on both sides.
- Used wherever datapaths need a wide adder that closes timing and can be back-pressured.

Parameters:
- WIDTH, 8, operand/result width in bits; must be an integer multiple of STAGES.
- STAGES, 2, number of pipeline stages; each stage resolves WIDTH/STAGES bits; range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / extra borrow-complement bit (sub)
- sub  input  1  0: a+b+cin; 1: a+~b+cin (cin=1 gives a-b)
- in_valid  input  1  a/b/cin/sub are valid this cycle
- in_ready  output  1  block accepts input this cycle
- sum  output  WIDTH  result
- carry  output  1  carry-out of the MSB (for sub: 1 = no borrow)
- overflow  output  1  two's-complement signed overflow
- out_valid  output  1  sum/carry/overflow are valid
- out_ready  input  1  downstream accepts output this cycle

Behaviour:
- Reset: rst sampled high at a rising edge clears every stage valid bit.
  - Outputs after reset: out_valid=0, sum=0, carry=0, overflow=0.
  - Operand/partial-sum data registers are also cleared to 0.
  - in_ready=1 the cycle after reset.
  - Reset overrides any in-flight transfer; in-flight results are discarded and never emitted.
- Operand preprocessing (combinational, before stage 0): b_eff = sub ? ~b : b; carry into slice 0 = cin.
- Slicing: let W = WIDTH/STAGES.
  - Stage k (0..STAGES-1) computes bits [k*W+W-1 : k*W] = a_slice + b_eff_slice + carry from stage k-1 (stage 0 uses cin).
  - It registers those sum bits, its carry-out and valid.
  - Unconsumed upper operand slices and already-computed lower sum slices are carried forward in the stage registers.
- Final stage outputs:
  - sum is the full WIDTH result.
  - carry = slice STAGES-1 carry-out.
  - overflow = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]), computed on operands carried down the pipe.
- Latency: an input accepted at rising edge t (in_valid && in_ready) presents its result with out_valid=1 after edge t+STAGES-1 (i.e. visible in the cycle following STAGES edges counting edge t).
- Throughput: one result per cycle when out_ready is held high.
- Handshake:
  - Transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
  - Global stall: stall = out_valid && !out_ready, and in_ready = !stall.
  - While stalled, all stage registers hold, including bubbles, and sum/carry/overflow/out_valid remain stable.
  - Inputs presented while in_ready=0 are ignored; upstream must hold them.
- Bubbles: a cycle with in_valid=0 (and no stall) inserts a stage with valid=0; bubbles propagate and never produce out_valid=1.
- Data stability: sum/carry/overflow may change only when a stage advance occurs. When out_valid=0, output data values are don't-care but must not be X after reset.
- Simultaneous events:
  - Output transfer and input acceptance in the same cycle are permitted (full pipeline moves one slot).
  - rst has priority over every handshake.
- Arithmetic wraps modulo 2^WIDTH; there is no saturation.
- STAGES=1 degenerates to a single registered adder with latency 1.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, sum=0, carry=0, overflow=0, in_ready=1 after release; no output from pre-reset inputs.
- Add (WIDTH=8, STAGES=2): a=8'hF0, b=8'h1F, cin=1, sub=0 -> after 2 edges sum=8'h10, carry=1, overflow=0; a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, carry=0, overflow=1.
- Subtract: a=8'h05, b=8'h07, sub=1, cin=1 -> sum=8'hFE, carry=0, overflow=0; a=8'h80, b=8'h01, sub=1, cin=1 -> sum=8'h7F, carry=1, overflow=1.
- Throughput: 16 back-to-back random inputs with out_ready=1 -> 16 consecutive out_valid cycles, results in order, matching the reference model.
- Back-pressure: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs stable for 3 cycles; on release there is no loss or duplication.
- Carry across slice boundary and reset mid-flight: a=8'h0F, b=8'h01 -> sum=8'h10. Separately, assert rst with 2 items in flight -> neither is emitted.
